// File: rtl/uart_result_tx_pkg.sv
// Shared definitions for the UART result transmitter: default widths,
// the default frame header value and the transmit FSM state encoding.
package uart_result_tx_pkg;

    localparam int         NB_DATA_DEF     = 8;
    localparam logic [7:0] HEADER_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        HDR   = 2'd3
    } state_e;

endpackage

// File: rtl/uart_result_tx_if.sv
// Signal bundle between the ALU/UART-TX side (master) and the result
// transmitter (slave). Clock and reset stay outside the bundle.
interface uart_result_tx_if
    import uart_result_tx_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF
);
    logic               i_result_valid;
    logic [NB_DATA-1:0] i_result;
    logic               o_result_ready;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               i_tx_done;
    logic               o_busy;
    logic               o_overflow;

    modport master (
        output i_result_valid, i_result, i_tx_done,
        input  o_result_ready, o_tx_data, o_tx_start, o_busy, o_overflow
    );

    modport slave (
        input  i_result_valid, i_result, i_tx_done,
        output o_result_ready, o_tx_data, o_tx_start, o_busy, o_overflow
    );

endinterface

// File: rtl/uart_result_tx_sync_fifo.sv
// Single-clock FIFO with registered full/empty flags. A push while full
// is ignored (the caller decides what that means); a pop while empty is
// ignored. Depth is 2**NB_PTR, pointers wrap naturally.
module sync_fifo #(
    parameter int NB_DATA = 8,
    parameter int NB_PTR  = 2
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               push_i,
    input  logic [NB_DATA-1:0] data_i,
    input  logic               pop_i,
    output logic [NB_DATA-1:0] data_o,
    output logic               full_o,
    output logic               empty_o
);
    localparam int                DEPTH   = 1 << NB_PTR;
    localparam logic [NB_PTR:0]   DEPTH_C = (NB_PTR + 1)'(DEPTH);

    logic [NB_DATA-1:0] mem_q [DEPTH];
    logic [NB_PTR-1:0]  wr_q, wr_d;
    logic [NB_PTR-1:0]  rd_q, rd_d;
    logic [NB_PTR:0]    cnt_q, cnt_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push;
    logic               do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next pointer/count/flag values from the qualified push and pop.
    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - 1'b1;
        end
        full_d  = (cnt_d == DEPTH_C);
        empty_d = (cnt_d == '0);
    end

    // Control state: pointers, occupancy and flags.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/uart_result_tx.sv
// Buffers ALU result bytes and hands them one at a time to a UART TX core
// through a start/done handshake. Optional build macro
// UART_RESULT_TX_HEADER_EN prefixes every result with HEADER_BYTE as its
// own UART frame; the result stays queued until the header is done.
module uart_result_tx
    import uart_result_tx_pkg::*;
#(
    parameter int                 NB_DATA     = NB_DATA_DEF,
    parameter int                 FIFO_DEPTH  = 4,
    parameter int                 NB_PTR      = 2,
    parameter logic [NB_DATA-1:0] HEADER_BYTE = HEADER_BYTE_DEF
) (
    input logic             i_clock,
    input logic             i_reset,
    uart_result_tx_if.slave bus
);
    state_e             state_q, state_d;
    logic [NB_DATA-1:0] tx_data_q, tx_data_d;
    logic               start_q, start_d;
    logic               ovf_q, ovf_d;
    logic               fifo_pop;
    logic [NB_DATA-1:0] fifo_head;
    logic               fifo_full;
    logic               fifo_empty;

    // FIFO_DEPTH is implied by NB_PTR; the relation is evaluated here only.
    logic unused_cfg;
    assign unused_cfg = (FIFO_DEPTH == (1 << NB_PTR));

    sync_fifo #(
        .NB_DATA (NB_DATA),
        .NB_PTR  (NB_PTR)
    ) u_fifo (
        .clk_i   (i_clock),
        .rst_ni  (i_reset),
        .push_i  (bus.i_result_valid),
        .data_i  (bus.i_result),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Transmit FSM: pop, load the byte, pulse start, wait for done.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        start_d   = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
`ifdef UART_RESULT_TX_HEADER_EN
                    tx_data_d = HEADER_BYTE;
                    start_d   = 1'b1;
                    state_d   = HDR;
`else
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    start_d   = 1'b1;
                    state_d   = START;
`endif
                end
            end
            START: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_tx_done) begin
                    state_d = IDLE;
                end
            end
            HDR: begin
`ifdef UART_RESULT_TX_HEADER_EN
                // A done coinciding with the header's own start pulse is spurious.
                if (bus.i_tx_done && !start_q) begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    start_d   = 1'b1;
                    state_d   = START;
                end
`else
                state_d = IDLE;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifndef UART_RESULT_TX_HEADER_EN
    logic unused_hdr;
    assign unused_hdr = ^HEADER_BYTE;
`endif

    assign ovf_d = ovf_q | (bus.i_result_valid & fifo_full);

    // State and output registers; reset drops start immediately.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q   <= IDLE;
            tx_data_q <= '0;
            start_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data_q <= tx_data_d;
            start_q   <= start_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.o_tx_data      = tx_data_q;
    assign bus.o_tx_start     = start_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_result_ready = !fifo_full;
    assign bus.o_busy         = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_result_tx.sv
// Directed bench for uart_result_tx (FIFO_DEPTH=4). Inputs change 1 ns
// after the rising edge; outputs are sampled at that same point.
module tb_uart_result_tx;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   starts = 0;
    int   double_start = 0;
    bit   pending = 0;
    int   s0;

    uart_result_tx_if #(.NB_DATA(8)) bus ();

    uart_result_tx #(
        .NB_DATA     (8),
        .FIFO_DEPTH  (4),
        .NB_PTR      (2),
        .HEADER_BYTE (8'hA5)
    ) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Start-pulse monitor: counts starts, flags a start without a done since the last one.
    always @(posedge clk) begin
        if (!rst_n) begin
            pending = 1'b0;
        end else begin
            if (bus.o_tx_start) begin
                starts++;
                if (pending) double_start++;
                pending = 1'b1;
            end else if (bus.i_tx_done) begin
                pending = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        bus.i_result_valid = 1'b1;
        bus.i_result       = v;
        tick();
        bus.i_result_valid = 1'b0;
    endtask

    task automatic done_pulse();
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        bus.i_result_valid = 1'b0;
        bus.i_result       = '0;
        bus.i_tx_done      = 1'b0;
        rst_n              = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_data", 32'(bus.o_tx_data), 32'h00);
        check("rst_tx_start", 32'(bus.o_tx_start), 0);
        check("rst_busy", 32'(bus.o_busy), 0);
        check("rst_overflow", 32'(bus.o_overflow), 0);
        check("rst_ready", 32'(bus.o_result_ready), 1);
        #4;
        rst_n = 1'b1;
        tick();

`ifdef UART_RESULT_TX_HEADER_EN
        // Header frame first; the result stays queued until the header's done.
        push(8'h0F);
        tick();
        check("hdr_start", 32'(bus.o_tx_start), 1);
        check("hdr_data", 32'(bus.o_tx_data), 32'hA5);
        bus.i_result_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            bus.i_result = 8'(i);
            tick();
        end
        bus.i_result_valid = 1'b0;
        check("hdr_fifo_full", 32'(bus.o_result_ready), 0);
        check("hdr_start_low", 32'(bus.o_tx_start), 0);
        done_pulse();
        check("hdr_res_start", 32'(bus.o_tx_start), 1);
        check("hdr_res_data", 32'(bus.o_tx_data), 32'h0F);
        check("hdr_ready_after_pop", 32'(bus.o_result_ready), 1);
        tick();
        check("hdr_res_start_end", 32'(bus.o_tx_start), 0);
        check("hdr_no_double", 32'(double_start), 0);
`else
        // Single result, done 10 cycles after the start pulse.
        push(8'h2A);
        check("t1_busy", 32'(bus.o_busy), 1);
        check("t1_start_early", 32'(bus.o_tx_start), 0);
        tick();
        check("t1_start", 32'(bus.o_tx_start), 1);
        check("t1_data", 32'(bus.o_tx_data), 32'h2A);
        tick();
        check("t1_start_end", 32'(bus.o_tx_start), 0);
        repeat (9) tick();
        check("t1_busy_wait", 32'(bus.o_busy), 1);
        done_pulse();
        check("t1_busy_fall", 32'(bus.o_busy), 0);
        check("t1_data_hold", 32'(bus.o_tx_data), 32'h2A);
        check("t1_starts", 32'(starts), 1);

        // Three back-to-back results sent in order.
        bus.i_result_valid = 1'b1;
        bus.i_result = 8'h01;
        tick();
        bus.i_result = 8'h02;
        tick();
        check("t2_start_01", 32'(bus.o_tx_start), 1);
        check("t2_data_01", 32'(bus.o_tx_data), 32'h01);
        bus.i_result = 8'h03;
        tick();
        bus.i_result_valid = 1'b0;
        check("t2_start_end", 32'(bus.o_tx_start), 0);
        for (int k = 2; k <= 3; k++) begin
            repeat (3) tick();
            done_pulse();
            check("t2_no_start_on_done", 32'(bus.o_tx_start), 0);
            tick();
            check("t2_start_next", 32'(bus.o_tx_start), 1);
            check("t2_data_next", 32'(bus.o_tx_data), 32'(k));
        end
        repeat (3) tick();
        done_pulse();
        check("t2_busy_fall", 32'(bus.o_busy), 0);
        check("t2_starts", 32'(starts), 4);

        // Overflow: one in flight + four buffered, sixth push dropped.
        bus.i_result_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.i_result = 8'h10 + 8'(i);
            tick();
        end
        check("t3_ready_full", 32'(bus.o_result_ready), 0);
        check("t3_ovf_before", 32'(bus.o_overflow), 0);
        bus.i_result = 8'h15;
        tick();
        bus.i_result_valid = 1'b0;
        check("t3_ovf_set", 32'(bus.o_overflow), 1);
        check("t3_ready_still_full", 32'(bus.o_result_ready), 0);
        for (int k = 0; k < 4; k++) begin
            done_pulse();
            tick();
            check("t3_drain_start", 32'(bus.o_tx_start), 1);
            check("t3_drain_data", 32'(bus.o_tx_data), 32'h11 + 32'(k));
            repeat (2) tick();
        end
        done_pulse();
        check("t3_busy_fall", 32'(bus.o_busy), 0);
        check("t3_ovf_sticky", 32'(bus.o_overflow), 1);
        check("t3_ready_back", 32'(bus.o_result_ready), 1);
        check("t3_starts", 32'(starts), 9);

        // Spurious done in IDLE and in START.
        s0 = starts;
        done_pulse();
        check("t4_idle_busy", 32'(bus.o_busy), 0);
        check("t4_idle_start", 32'(bus.o_tx_start), 0);
        push(8'h20);
        tick();
        check("t4_start", 32'(bus.o_tx_start), 1);
        check("t4_data", 32'(bus.o_tx_data), 32'h20);
        bus.i_tx_done = 1'b1;
        tick();
        bus.i_tx_done = 1'b0;
        check("t4_start_end", 32'(bus.o_tx_start), 0);
        check("t4_still_busy", 32'(bus.o_busy), 1);
        repeat (3) tick();
        check("t4_busy_wait", 32'(bus.o_busy), 1);
        check("t4_starts", 32'(starts), 32'(s0 + 1));
        done_pulse();
        check("t4_busy_fall", 32'(bus.o_busy), 0);

        // Asynchronous reset in WAIT with two entries queued.
        bus.i_result_valid = 1'b1;
        bus.i_result = 8'h30;
        tick();
        bus.i_result = 8'h31;
        tick();
        bus.i_result = 8'h32;
        tick();
        bus.i_result_valid = 1'b0;
        tick();
        check("t5_busy_pre", 32'(bus.o_busy), 1);
        s0 = starts;
        rst_n = 1'b0;
        #2;
        check("t5_rst_data", 32'(bus.o_tx_data), 32'h00);
        check("t5_rst_start", 32'(bus.o_tx_start), 0);
        check("t5_rst_busy", 32'(bus.o_busy), 0);
        check("t5_rst_ovf", 32'(bus.o_overflow), 0);
        check("t5_rst_ready", 32'(bus.o_result_ready), 1);
        @(posedge clk);
        #5;
        rst_n = 1'b1;
        repeat (10) tick();
        check("t5_idle_busy", 32'(bus.o_busy), 0);
        check("t5_no_tx", 32'(starts), 32'(s0));
        push(8'h33);
        tick();
        check("t5_new_start", 32'(bus.o_tx_start), 1);
        check("t5_new_data", 32'(bus.o_tx_data), 32'h33);
        repeat (2) tick();
        done_pulse();
        check("t5_busy_fall", 32'(bus.o_busy), 0);
        check("no_double_start", 32'(double_start), 0);
`endif
        do_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
